tt_alu_top: RTL and testbench
=============================

TT_ALU_TOP -- requirements
Module: tt_alu_top

Interface
REQ-001 The block SHALL have no parameters; the datapath width SHALL be fixed at 8 bits.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset; clk and rst_n are the only timing inputs.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 ena  input  1  design enable; 1 = operate, 0 = hold all state.
REQ-006 ui_in  input  8  data byte, sampled only by the load opcodes.
REQ-007 uio_in  input  8  [3:0] = opcode; [7:4] are ignored.
REQ-008 uo_out  output  8  registered result R.
REQ-009 uio_out  output  8  [4]=Z, [5]=C, [6]=N, [7]=V (registered flags); [3:0] SHALL be constant 0.
REQ-010 uio_oe  output  8  SHALL be the constant 8'hF0.

Function
REQ-011 The block SHALL hold 8-bit registers A, B and R plus a 4-bit flag register {V,N,C,Z}.
REQ-012 On each rising edge with rst_n=1 and ena=1, the block SHALL sample the opcode and act on the pre-edge values of A and B; results SHALL appear on the outputs after that edge (1-cycle latency).
REQ-013 When ena=0, all registers SHALL hold their values.
REQ-014 Opcodes: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 NOT A; 6 SHL A by B[2:0]; 7 SHR logical by B[2:0]; 8 SRA by B[2:0]; 9 ROL A by B[2:0]; A INC A; B DEC A; C MUL low byte of A*B; D MUL high byte of A*B; E LOAD A=ui_in; F LOAD B=ui_in.
REQ-015 Opcodes E and F SHALL NOT modify R or the flags; opcodes 0-D SHALL NOT modify A or B.
REQ-016 For opcodes 0-D: Z SHALL be 1 iff the new R is 0; N SHALL equal the new R[7].
REQ-017 C, carry: ADD = carry out of bit 7; SUB = borrow (A<B unsigned); INC = (A==FF); DEC = (A==00).
REQ-018 C, shifts: SHL = A[8-n]; SHR and SRA = A[n-1]; C SHALL be 0 when n=0.
REQ-019 C, multiply: MUL-low and MUL-high = (high byte of product != 0).
REQ-020 C SHALL be 0 for all other opcodes.
REQ-021 V SHALL be the two's-complement overflow for ADD, SUB, INC (A=7F) and DEC (A=80), and 0 for all other opcodes.
REQ-022 All arithmetic SHALL wrap modulo 256; the multiply SHALL be unsigned 8x8 to 16 bits.
REQ-023 Executing the same opcode in consecutive cycles SHALL recompute R from the current A and B every cycle.

Reset
REQ-024 While rst_n=0 at a rising edge, the block SHALL set A, B and R to 0x00 and the flags to {V,N,C,Z}=0001, regardless of ena.
REQ-025 After reset, uo_out SHALL be 0x00 and uio_out SHALL be 0x10; uio_oe SHALL remain 0xF0 at all times.
REQ-026 A reset during any operation SHALL take priority; the pending result SHALL be discarded.

Structure
REQ-027 A package tt_alu_pkg SHALL hold the opcode enum (4 bits) and the flag bit-index constants.
REQ-028 A combinational sub-module tt_alu_core SHALL compute the result and flags from A, B and the opcode; tt_alu_top SHALL hold the registers and the pin mapping.

Verification
REQ-029 Reset: hold rst_n=0 for 2 cycles -> uo_out=00, uio_out=10, uio_oe=F0.
REQ-030 Load A=7F (op E), load B=01 (op F), then ADD -> uo_out=80, uio_out=C0.
REQ-031 A=05, B=07, SUB -> uo_out=FE, uio_out=60.
REQ-032 A=10, B=20: MUL-low -> uo_out=00, uio_out=30; then MUL-high -> uo_out=02, uio_out=20.
REQ-033 A=81, B=01, SRA -> uo_out=C0, uio_out=60; then SHL -> uo_out=02, uio_out=20.
REQ-034 With R=80, set ena=0 and apply op 5 -> R stays 80; then assert rst_n=0 with ena=0 -> uo_out=00, uio_out=10.

Source files
------------

// File: rtl/tt_alu_pkg.sv
// Shared definitions for the 8-bit register ALU: opcode encoding,
// flag-register bit positions and small opcode classification helpers.
package tt_alu_pkg;

   localparam int unsigned DW = 8;
   localparam int unsigned FW = 4;

   // Flag register layout is {V,N,C,Z}; these are bit positions within it.
   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_V = 3;

   // Value of the flag register out of reset: only Z set (R = 0).
   localparam logic [FW-1:0] FLAGS_RST = 4'b0001;

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_AND  = 4'h2,
      OP_OR   = 4'h3,
      OP_XOR  = 4'h4,
      OP_NOT  = 4'h5,
      OP_SHL  = 4'h6,
      OP_SHR  = 4'h7,
      OP_SRA  = 4'h8,
      OP_ROL  = 4'h9,
      OP_INC  = 4'hA,
      OP_DEC  = 4'hB,
      OP_MULL = 4'hC,
      OP_MULH = 4'hD,
      OP_LDA  = 4'hE,
      OP_LDB  = 4'hF
   } op_e;

   // Load opcodes only touch the operand registers, never R or the flags.
   function automatic logic is_load(input op_e op);
      return (op == OP_LDA) || (op == OP_LDB);
   endfunction

endpackage

// File: rtl/tt_alu_core.sv
// Purely combinational ALU datapath: result and {V,N,C,Z} from A, B and
// the opcode, plus strobes telling the top which registers to update.
module tt_alu_core
   import tt_alu_pkg::*;
(
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   input  op_e           op_i,
   output logic [DW-1:0] result_o,
   output logic [FW-1:0] flags_o,
   output logic          wr_res_o,
   output logic          ld_a_o,
   output logic          ld_b_o
);

   logic [2:0]      shamt;
   logic [DW:0]     sum9;
   logic [DW-1:0]   diff;
   logic [DW:0]     shl9;
   logic [DW:0]     shr9;
   logic [DW-1:0]   sra8;
   logic [DW-1:0]   rol8;
   logic [DW-1:0]   inc8;
   logic [DW-1:0]   dec8;
   logic [2*DW-1:0] prod;

   logic [DW-1:0]   res;
   logic            c_flag;
   logic            v_flag;

   assign shamt = b_i[2:0];
   assign sum9  = {1'b0, a_i} + {1'b0, b_i};
   assign diff  = a_i - b_i;
   // Bit 8 of the widened left shift is the last bit shifted out (A[8-n]);
   // it is naturally 0 when n = 0.
   assign shl9  = {1'b0, a_i} << shamt;
   // Bit 0 of the widened right shift is the last bit shifted out (A[n-1]);
   // it is naturally 0 when n = 0. SRA shifts out the same bit.
   assign shr9  = {a_i, 1'b0} >> shamt;
   assign sra8  = $unsigned($signed(a_i) >>> shamt);
   // An 8-bit right shift by 8 yields 0, so n = 0 rotates to A unchanged.
   assign rol8  = (a_i << shamt) | (a_i >> (4'd8 - {1'b0, shamt}));
   assign inc8  = a_i + 8'h01;
   assign dec8  = a_i - 8'h01;
   assign prod  = {8'h00, a_i} * {8'h00, b_i};

   // Opcode decode: result value, carry/overflow and register write strobes.
   always_comb begin
      res      = '0;
      c_flag   = 1'b0;
      v_flag   = 1'b0;
      wr_res_o = 1'b1;
      ld_a_o   = 1'b0;
      ld_b_o   = 1'b0;
      unique case (op_i)
         OP_ADD: begin
            res    = sum9[DW-1:0];
            c_flag = sum9[DW];
            v_flag = (a_i[7] == b_i[7]) && (sum9[7] != a_i[7]);
         end
         OP_SUB: begin
            res    = diff;
            c_flag = (a_i < b_i);
            v_flag = (a_i[7] != b_i[7]) && (diff[7] != a_i[7]);
         end
         OP_AND: res = a_i & b_i;
         OP_OR:  res = a_i | b_i;
         OP_XOR: res = a_i ^ b_i;
         OP_NOT: res = ~a_i;
         OP_SHL: begin
            res    = shl9[DW-1:0];
            c_flag = shl9[DW];
         end
         OP_SHR: begin
            res    = shr9[DW:1];
            c_flag = shr9[0];
         end
         OP_SRA: begin
            res    = sra8;
            c_flag = shr9[0];
         end
         OP_ROL: res = rol8;
         OP_INC: begin
            res    = inc8;
            c_flag = (a_i == 8'hFF);
            v_flag = (a_i == 8'h7F);
         end
         OP_DEC: begin
            res    = dec8;
            c_flag = (a_i == 8'h00);
            v_flag = (a_i == 8'h80);
         end
         OP_MULL: begin
            res    = prod[DW-1:0];
            c_flag = (prod[2*DW-1:DW] != 8'h00);
         end
         OP_MULH: begin
            res    = prod[2*DW-1:DW];
            c_flag = (prod[2*DW-1:DW] != 8'h00);
         end
         OP_LDA: begin
            wr_res_o = 1'b0;
            ld_a_o   = 1'b1;
         end
         OP_LDB: begin
            wr_res_o = 1'b0;
            ld_b_o   = 1'b1;
         end
         default: wr_res_o = 1'b0;
      endcase
   end

   // Flag assembly; Z and N follow the new result for every writing opcode.
   always_comb begin
      flags_o         = '0;
      flags_o[FLAG_Z] = (res == 8'h00);
      flags_o[FLAG_C] = c_flag;
      flags_o[FLAG_N] = res[7];
      flags_o[FLAG_V] = v_flag;
   end

   assign result_o = res;

endmodule

// File: rtl/tt_alu_top.sv
// 8-bit register ALU top: operand registers A/B, result R and flags,
// with the pin mapping onto the ui/uo/uio pad groups.
module tt_alu_top
   import tt_alu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [DW-1:0] r_q, r_d;
   logic [FW-1:0] flags_q, flags_d;

   op_e           op;
   logic [DW-1:0] core_res;
   logic [FW-1:0] core_flags;
   logic          core_wr_res;
   logic          core_ld_a;
   logic          core_ld_b;

   // Upper opcode-pad bits carry no meaning for this block.
   logic          unused_uio_hi;
   assign unused_uio_hi = &{1'b0, uio_in[7:4]};

   assign op = op_e'(uio_in[3:0]);

   tt_alu_core u_core (
      .a_i      (a_q),
      .b_i      (b_q),
      .op_i     (op),
      .result_o (core_res),
      .flags_o  (core_flags),
      .wr_res_o (core_wr_res),
      .ld_a_o   (core_ld_a),
      .ld_b_o   (core_ld_b)
   );

   // Next-state selection; everything holds while ena is low.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      flags_d = flags_q;
      if (ena) begin
         if (core_ld_a) a_d = ui_in;
         if (core_ld_b) b_d = ui_in;
         if (core_wr_res) begin
            r_d     = core_res;
            flags_d = core_flags;
         end
      end
   end

   // State registers; synchronous reset wins over ena and any pending op.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         flags_q <= FLAGS_RST;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         flags_q <= flags_d;
      end
   end

   assign uo_out  = r_q;
   assign uio_out = {flags_q, 4'b0000};
   assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_alu_top.sv
// Directed bench for tt_alu_top: each task drives a scenario and checks
// {uo_out, uio_out, uio_oe} against hand-computed values.
module tb_tt_alu_top;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int tests_run;
   int tests_failed;

   tt_alu_top dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one opcode for one clock edge, then settle 1 time unit after it.
   task automatic step(input logic [3:0] op, input logic [7:0] data);
      uio_in = {4'h0, op};
      ui_in  = data;
      @(posedge clk);
      #1;
   endtask

   task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
      step(4'hE, a);
      step(4'hF, b);
   endtask

   task automatic test_reset();
      logic [23:0] got;
      rst_n = 1'b0;
      ena   = 1'b1;
      step(4'h0, 8'h00);
      step(4'h0, 8'h00);
      got = {uo_out, uio_out, uio_oe};
      tests_run++;
      if (got !== 24'h0010F0) begin
         tests_failed++;
         $display("FAIL reset: got %h expected %h", got, 24'h0010F0);
      end
      rst_n = 1'b1;
   endtask

   // Vector table: {A, B, op, expected uo_out, expected uio_out}
   task automatic test_vectors();
      logic [39:0] vec [0:21];
      logic [15:0] got;
      vec[0]  = {8'h7F, 8'h01, 8'h00, 8'h80, 8'hC0}; // ADD overflow
      vec[1]  = {8'hFF, 8'h01, 8'h00, 8'h00, 8'h30}; // ADD carry, zero
      vec[2]  = {8'h05, 8'h07, 8'h01, 8'hFE, 8'h60}; // SUB borrow
      vec[3]  = {8'h80, 8'h01, 8'h01, 8'h7F, 8'h80}; // SUB overflow
      vec[4]  = {8'hC3, 8'h5A, 8'h02, 8'h42, 8'h00}; // AND
      vec[5]  = {8'hC3, 8'h5A, 8'h03, 8'hDB, 8'h40}; // OR
      vec[6]  = {8'hC3, 8'h5A, 8'h04, 8'h99, 8'h40}; // XOR
      vec[7]  = {8'hC3, 8'h5A, 8'h05, 8'h3C, 8'h00}; // NOT
      vec[8]  = {8'h10, 8'h20, 8'h0C, 8'h00, 8'h30}; // MUL low
      vec[9]  = {8'h10, 8'h20, 8'h0D, 8'h02, 8'h20}; // MUL high
      vec[10] = {8'h0F, 8'h0F, 8'h0C, 8'hE1, 8'h40}; // MUL low, no high
      vec[11] = {8'h81, 8'h01, 8'h08, 8'hC0, 8'h60}; // SRA
      vec[12] = {8'h81, 8'h01, 8'h06, 8'h02, 8'h20}; // SHL carry
      vec[13] = {8'h81, 8'h08, 8'h06, 8'h81, 8'h40}; // SHL n=0, C=0
      vec[14] = {8'h03, 8'h07, 8'h06, 8'h80, 8'h60}; // SHL n=7
      vec[15] = {8'h81, 8'h04, 8'h07, 8'h08, 8'h00}; // SHR n=4
      vec[16] = {8'h81, 8'h08, 8'h07, 8'h81, 8'h40}; // SHR n=0
      vec[17] = {8'h96, 8'h03, 8'h09, 8'hB4, 8'h40}; // ROL 3
      vec[18] = {8'hFF, 8'h00, 8'h0A, 8'h00, 8'h30}; // INC wrap
      vec[19] = {8'h7F, 8'h00, 8'h0A, 8'h80, 8'hC0}; // INC overflow
      vec[20] = {8'h80, 8'h00, 8'h0B, 8'h7F, 8'h80}; // DEC overflow
      vec[21] = {8'h00, 8'h00, 8'h0B, 8'hFF, 8'h60}; // DEC borrow
      for (int i = 0; i < 22; i++) begin
         load_ab(vec[i][39:32], vec[i][31:24]);
         step(vec[i][19:16], 8'hA5);
         got = {uo_out, uio_out};
         tests_run++;
         if (got !== vec[i][15:0] || uio_oe !== 8'hF0) begin
            tests_failed++;
            $display("FAIL vector_%0d: got %h/%h expected %h/F0", i, got, uio_oe, vec[i][15:0]);
         end
      end
   endtask

   task automatic test_load_preserves();
      logic [15:0] got;
      load_ab(8'hC3, 8'h5A);
      step(4'h4, 8'h00);          // XOR -> 99, N
      step(4'hE, 8'h00);          // A = 00, R/flags untouched
      step(4'hF, 8'h00);
      got = {uo_out, uio_out};
      tests_run++;
      if (got !== 16'h9940) begin
         tests_failed++;
         $display("FAIL load_preserves: got %h expected %h", got, 16'h9940);
      end
      step(4'h5, 8'h00);          // NOT A proves A was loaded with 00
      got = {uo_out, uio_out};
      tests_run++;
      if (got !== 16'hFF40) begin
         tests_failed++;
         $display("FAIL load_then_not: got %h expected %h", got, 16'hFF40);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] got;
      load_ab(8'h01, 8'h01);
      step(4'h0, 8'h00);
      step(4'h0, 8'h00);
      got = {uo_out, uio_out};
      tests_run++;
      if (got !== 16'h0200) begin
         tests_failed++;
         $display("FAIL b2b_add: got %h expected %h", got, 16'h0200);
      end
      step(4'hF, 8'h03);
      step(4'h0, 8'h00);
      got = {uo_out, uio_out};
      tests_run++;
      if (got !== 16'h0400) begin
         tests_failed++;
         $display("FAIL b2b_add_newb: got %h expected %h", got, 16'h0400);
      end
      // Upper opcode bits must be ignored: 0x5A decodes as INC.
      uio_in = 8'h5A;
      ui_in  = 8'h00;
      @(posedge clk);
      #1;
      got = {uo_out, uio_out};
      tests_run++;
      if (got !== 16'h0200) begin
         tests_failed++;
         $display("FAIL upper_bits_ignored: got %h expected %h", got, 16'h0200);
      end
   endtask

   task automatic test_hold_and_reset();
      logic [15:0] got;
      load_ab(8'h7F, 8'h01);
      step(4'h0, 8'h00);          // R = 80, flags C0
      ena = 1'b0;
      step(4'h5, 8'h00);
      step(4'hE, 8'h55);          // must not load A
      got = {uo_out, uio_out};
      tests_run++;
      if (got !== 16'h80C0) begin
         tests_failed++;
         $display("FAIL ena_hold: got %h expected %h", got, 16'h80C0);
      end
      ena = 1'b1;
      step(4'h0, 8'h00);          // A still 7F, B 01 -> 80 again
      got = {uo_out, uio_out};
      tests_run++;
      if (got !== 16'h80C0) begin
         tests_failed++;
         $display("FAIL ena_hold_ab: got %h expected %h", got, 16'h80C0);
      end
      ena   = 1'b0;
      rst_n = 1'b0;
      step(4'h5, 8'h00);
      got = {uo_out, uio_out};
      tests_run++;
      if (got !== 16'h0010 || uio_oe !== 8'hF0) begin
         tests_failed++;
         $display("FAIL reset_ena0: got %h/%h expected %h/F0", got, uio_oe, 16'h0010);
      end
      rst_n = 1'b1;
      ena   = 1'b1;
      load_ab(8'h33, 8'h44);
      rst_n = 1'b0;
      step(4'h0, 8'h00);          // reset wins over the pending ADD
      got = {uo_out, uio_out};
      tests_run++;
      if (got !== 16'h0010) begin
         tests_failed++;
         $display("FAIL reset_priority: got %h expected %h", got, 16'h0010);
      end
      rst_n = 1'b1;
      step(4'h3, 8'h00);          // A|B after reset = 0 -> Z
      got = {uo_out, uio_out};
      tests_run++;
      if (got !== 16'h0010) begin
         tests_failed++;
         $display("FAIL reset_clears_ab: got %h expected %h", got, 16'h0010);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      ena          = 1'b0;
      ui_in        = 8'h00;
      uio_in       = 8'h00;
      test_reset();
      test_vectors();
      test_load_preserves();
      test_back_to_back();
      test_hold_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
